// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and helpers for the SDRAM host-port arbiter
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} arb_state_t;
  localparam int LEN_W = 8;
  function automatic int rr_wrap(input int i, input int n);
    return i % n;
  endfunction
endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after last
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                        req,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] last,
  output logic                                valid,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] idx
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  assign valid = |req;
  // Scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    idx = '0;
    for (int i = N; i >= 1; i--)
      if (req[rr_wrap(int'(last) + i, N)]) idx = IW'(rr_wrap(int'(last) + i, N));
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin sharing of the SDRAM controller host port
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS  = 4,
  parameter int ASIZE   = 23,
  parameter int DSIZE   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [NPORTS-1:0]         P_REQ,
  input  logic [NPORTS-1:0]         P_WR,
  input  logic [NPORTS*ASIZE-1:0]   P_ADDR,
  input  logic [NPORTS*LEN_W-1:0]   P_LEN,
  input  logic [NPORTS*DSIZE-1:0]   P_WDATA,
  output logic [NPORTS-1:0]         P_GNT,
  output logic [NPORTS-1:0]         P_WREQ,
  output logic [NPORTS-1:0]         P_RVALID,
  output logic [DSIZE-1:0]          P_RDATA,
  output logic [NPORTS-1:0]         P_DONE,
  output logic                      ERR,
  output logic [ASIZE-1:0]          C_ADDR,
  output logic [LEN_W-1:0]          C_LENGTH,
  output logic                      C_WR,
  output logic                      C_RD,
  output logic [DSIZE-1:0]          C_DATAIN,
  input  logic                      C_DONE,
  input  logic                      C_IN_REQ,
  input  logic                      C_OUT_VALID,
  input  logic [DSIZE-1:0]          C_DATAOUT
);
  localparam int IW = $clog2(NPORTS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [NPORTS-1:0] ONE = NPORTS'(1);
  arb_state_t state, state_nx;
  logic [IW-1:0] g, last, pick_i;
  logic pick_v, wr, active, timeout;
  logic [CW-1:0] cnt;
  logic [NPORTS-1:0] sel;
  rr_pick #(.N(NPORTS)) u_pick (.req(P_REQ), .last(last), .valid(pick_v), .idx(pick_i));
  assign sel      = ONE << g;
  assign active   = state == ISSUE || state == WAIT;
  assign timeout  = cnt == CW'(TIMEOUT);
  assign P_WREQ   = active && wr && C_IN_REQ ? sel : '0;
  assign P_RVALID = active && !wr && C_OUT_VALID ? sel : '0;
  assign C_DATAIN = active ? P_WDATA[int'(g)*DSIZE +: DSIZE] : '0;
  assign P_RDATA  = C_DATAOUT;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_v) state_nx = P_LEN[int'(pick_i)*LEN_W +: LEN_W] == '0 ? GAP : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (C_DONE || timeout) state_nx = GAP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      g        <= '0;
      last     <= IW'(NPORTS - 1);
      wr       <= 1'b0;
      cnt      <= '0;
      C_ADDR   <= '0;
      C_LENGTH <= '0;
      C_WR     <= 1'b0;
      C_RD     <= 1'b0;
      P_GNT    <= '0;
      P_DONE   <= '0;
      ERR      <= 1'b0;
    end else begin
      state  <= state_nx;
      P_GNT  <= '0;
      P_DONE <= '0;
      if (state == IDLE && pick_v) begin
        g        <= pick_i;
        last     <= pick_i;
        wr       <= P_WR[pick_i];
        C_ADDR   <= P_ADDR[int'(pick_i)*ASIZE +: ASIZE];
        C_LENGTH <= P_LEN[int'(pick_i)*LEN_W +: LEN_W];
        P_GNT    <= ONE << pick_i;
      end
      // The counter runs from ISSUE so a timeout drops the command TIMEOUT+1 cycles after ISSUE
      if (state == IDLE) cnt <= '0;
      else if (active && !timeout) cnt <= cnt + 1'b1;
      C_WR <= state_nx == WAIT && wr;
      C_RD <= state_nx == WAIT && !wr;
      if (state == WAIT && C_DONE) P_DONE <= sel;
      if (state == GAP && C_LENGTH == '0) P_DONE <= sel;
      if (state == WAIT && !C_DONE && timeout) ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed vectors plus a small controller responder model
module tb_sdram_port_arbiter;
  localparam int N = 4, AW = 23, DW = 16, LW = 8;
  logic CLK = 0, RESET_N = 0;
  logic [N-1:0] P_REQ = '0, P_WR = '0;
  logic [N*AW-1:0] P_ADDR = '0;
  logic [N*LW-1:0] P_LEN = '0;
  logic [N*DW-1:0] P_WDATA = '0;
  logic [N-1:0] P_GNT, P_WREQ, P_RVALID, P_DONE;
  logic [DW-1:0] P_RDATA, C_DATAIN, C_DATAOUT;
  logic ERR, C_WR, C_RD, C_DONE, C_IN_REQ, C_OUT_VALID;
  logic [AW-1:0] C_ADDR;
  logic [LW-1:0] C_LENGTH;
  logic auto_en = 1, no_done = 0;
  int nwords = 0, ph, k, pass_cnt = 0, total = 0;

  sdram_port_arbiter #(.NPORTS(N), .ASIZE(AW), .DSIZE(DW), .TIMEOUT(15)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .P_REQ(P_REQ), .P_WR(P_WR), .P_ADDR(P_ADDR),
    .P_LEN(P_LEN), .P_WDATA(P_WDATA), .P_GNT(P_GNT), .P_WREQ(P_WREQ),
    .P_RVALID(P_RVALID), .P_RDATA(P_RDATA), .P_DONE(P_DONE), .ERR(ERR),
    .C_ADDR(C_ADDR), .C_LENGTH(C_LENGTH), .C_WR(C_WR), .C_RD(C_RD),
    .C_DATAIN(C_DATAIN), .C_DONE(C_DONE), .C_IN_REQ(C_IN_REQ),
    .C_OUT_VALID(C_OUT_VALID), .C_DATAOUT(C_DATAOUT));

  always #5 CLK = ~CLK;

  // Controller model: nwords data beats after the command rises, then C_DONE unless no_done
  always @(posedge CLK) begin
    if (!auto_en || !RESET_N) begin
      ph <= 0; k <= 0; C_IN_REQ <= 0; C_OUT_VALID <= 0; C_DONE <= 0; C_DATAOUT <= '0;
    end else case (ph)
      0: if (C_WR || C_RD) begin ph <= 1; k <= 0; end
      1: if (k == nwords) begin
           ph <= 2; C_IN_REQ <= 0; C_OUT_VALID <= 0; C_DONE <= !no_done;
         end else begin
           C_IN_REQ <= C_WR; C_OUT_VALID <= C_RD; C_DATAOUT <= 16'hA000 + 16'(k); k <= k + 1;
         end
      2: begin C_DONE <= 0; ph <= 3; end
      default: if (!C_WR && !C_RD) ph <= 0;
    endcase
  end

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  typedef struct { logic [N-1:0] req; logic [N-1:0] gnt; } vec_t;
  vec_t tbl[8];

  initial begin
    int c_gnt, c_gnt1, c_rise, c_drop, c_done, nbeat, ndone, bad;
    int order[6], ng;
    logic [N-1:0] got;
    tbl[0] = '{4'b1111, 4'b0001}; tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001}; tbl[3] = '{4'b1001, 4'b1000};
    tbl[4] = '{4'b1000, 4'b1000}; tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b0101, 4'b0100}; tbl[7] = '{4'b0011, 4'b0001};
    tick; tick;
    chk("rst_cmd", {C_WR, C_RD, ERR}, 0);
    chk("rst_port", {P_GNT, P_DONE, P_WREQ, P_RVALID}, 0);
    chk("rst_addr", {C_ADDR, C_LENGTH}, 0);
    RESET_N = 1; tick;

    // Zero-length requests: grant then P_DONE one cycle later, arbitration order from the table
    for (int v = 0; v < 8; v++) begin
      P_REQ = tbl[v].req; got = '0;
      for (int c = 0; c < 10 && got == '0; c++) begin tick; got = P_GNT; end
      P_REQ = '0;
      chk("tbl_gnt", got, tbl[v].gnt);
      chk("tbl_nocmd", {C_WR, C_RD}, 0);
      tick;
      chk("tbl_done", P_DONE, tbl[v].gnt);
      tick;
    end

    // Single write on port 2 (last granted is 0)
    P_WR[2] = 1; P_ADDR[2*AW +: AW] = 23'h000100; P_LEN[2*LW +: LW] = 8;
    P_WDATA[2*DW +: DW] = 16'hBEEF; nwords = 8; P_REQ = 4'b0100;
    c_gnt = -1; c_rise = -1; c_drop = -1; c_done = -1; nbeat = 0; ndone = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (P_GNT != 0) begin c_gnt = c; P_REQ = '0; if (P_GNT != 4'b0100) bad++; end
      if (C_WR && c_rise < 0) c_rise = c;
      if (C_WR && c_drop >= 0) bad++;
      if (!C_WR && c_rise >= 0 && c_drop < 0) c_drop = c;
      if (C_WR && (C_ADDR != 23'h100 || C_LENGTH != 8)) bad++;
      if (P_WREQ[2]) begin nbeat++; if (C_DATAIN !== 16'hBEEF) bad++; end
      if ((P_WREQ & 4'b1011) != 0 || P_RVALID != 0 || C_RD) bad++;
      if (P_DONE != 0) begin ndone++; c_done = c; end
    end
    chk("wr_rise", c_rise, c_gnt + 1);
    chk("wr_beats", nbeat, 8);
    chk("wr_done_cnt", ndone, 1);
    chk("wr_done_at_drop", c_done, c_drop);
    chk("wr_bad", bad, 0);

    // Port 1 read (LEN 0xFF) and port 3 zero-length together; last=2 so port 3 goes first
    P_WR[1] = 0; P_LEN[1*LW +: LW] = 8'hFF; P_ADDR[1*AW +: AW] = 23'h2345;
    P_LEN[3*LW +: LW] = 0; nwords = 5; P_REQ = 4'b1010;
    c_gnt = -1; c_gnt1 = -1; c_rise = -1; c_done = -1; nbeat = 0; ndone = 0; bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick;
      if (P_GNT[3]) begin c_gnt = c; P_REQ[3] = 0; end
      if (P_GNT[1]) begin c_gnt1 = c; P_REQ[1] = 0; end
      if (C_RD && c_rise < 0) c_rise = c;
      if (P_DONE[3]) c_done = c;
      if (P_DONE[1]) ndone++;
      if (P_RVALID[1] !== C_OUT_VALID || P_RDATA !== C_DATAOUT) bad++;
      if ((P_RVALID & 4'b1101) != 0 || P_WREQ != 0 || C_WR) bad++;
      if (P_RVALID[1]) nbeat++;
    end
    chk("rd_len0_first", c_gnt1 > c_gnt && c_gnt >= 0, 1);
    chk("rd_len0_done", c_done, c_gnt + 1);
    chk("rd_rise", c_rise, c_gnt1 + 1);
    chk("rd_beats", nbeat, 5);
    chk("rd_done_cnt", ndone, 1);
    chk("rd_bad", bad, 0);

    // Timeout on port 0 read: command drops 16 cycles after ISSUE, ERR sticks, no P_DONE
    P_WR[0] = 0; P_LEN[0 +: LW] = 16; nwords = 3; no_done = 1; P_REQ = 4'b0001;
    c_gnt = -1; c_rise = -1; c_drop = -1; ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (P_GNT[0]) begin c_gnt = c; P_REQ = '0; end
      if (C_RD && c_rise < 0) c_rise = c;
      if (!C_RD && c_rise >= 0 && c_drop < 0) c_drop = c;
      if (P_DONE != 0) ndone++;
    end
    chk("to_rise", c_rise, c_gnt + 1);
    chk("to_drop", c_drop, c_gnt + 16);
    chk("to_err", ERR, 1);
    chk("to_no_done", ndone, 0);
    no_done = 0; nwords = 2; P_WR[2] = 1; P_LEN[2*LW +: LW] = 2; P_REQ = 4'b0100; ndone = 0;
    for (int c = 0; c < 30 && ndone == 0; c++) begin
      tick;
      if (P_GNT[2]) P_REQ = '0;
      if (P_DONE[2]) ndone++;
    end
    chk("to_next_served", ndone, 1);
    chk("to_err_sticky", ERR, 1);

    // Reset pulse mid-WAIT on a port 1 write
    P_WR[1] = 1; P_LEN[1*LW +: LW] = 8; nwords = 8; P_REQ = 4'b0010;
    for (int c = 0; c < 20 && !C_WR; c++) begin tick; if (P_GNT[1]) P_REQ = '0; end
    chk("rst_mid_wr_up", C_WR, 1);
    tick; tick;
    P_REQ = '0; RESET_N = 0; #1;
    chk("rst_mid_cmd", {C_WR, C_RD, ERR}, 0);
    chk("rst_mid_port", {P_GNT, P_DONE, P_WREQ, P_RVALID}, 0);
    tick; RESET_N = 1;

    // All ports continuously requesting writes of 4 words
    P_WR = 4'b1111; nwords = 4;
    for (int i = 0; i < N; i++) P_LEN[i*LW +: LW] = 4;
    P_REQ = 4'b1111; ng = 0;
    for (int c = 0; c < 300 && ng < 6; c++) begin
      tick;
      for (int i = 0; i < N; i++) if (P_GNT[i] && ng < 6) begin order[ng] = i; ng++; end
    end
    P_REQ = '0;
    chk("rr_count", ng, 6);
    for (int i = 0; i < 6; i++) chk("rr_order", (i < ng) ? order[i] : -1, i % N);
    for (int c = 0; c < 30; c++) tick;
    chk("rr_idle", {C_WR, C_RD}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
